vram_line_fetch: RTL

VRAM_LINE_FETCH -- requirements
Module: vram_line_fetch

---
 rtl/vram_line_fetch.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vram_line_fetch.sv
// Burst reader: walks consecutive VRAM word addresses, one outstanding read at a time,
// and queues returned words in a small FIFO for a ready/valid consumer.
module vram_line_fetch #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [14:0] base_addr,
  input  logic [8:0]  word_count,
  input  logic        abort,
  output logic [14:0] bus_addr,
  output logic        bus_strobe,
  input  logic        bus_ack,
  input  logic [31:0] bus_rddata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_next;
  logic [14:0] cur_addr, cur_addr_next;
  logic [8:0]  remaining, remaining_next;
  logic        pending, pending_next;
  logic        done_q, done_next;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_after;
  logic          push, pop, space;

  // pending marks that a strobe was issued last cycle; WAIT without it is a FIFO-full stall
  always_comb begin
    pop         = out_ready && (count != '0);
    push        = (state == WAIT) && pending && bus_ack && !abort;
    count_after = count + CW'(push) - CW'(pop);
    space       = count_after < CW'(FIFO_DEPTH);
  end

  always_comb begin
    state_next     = state;
    cur_addr_next  = cur_addr;
    remaining_next = remaining;
    pending_next   = pending;
    done_next      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            done_next = 1'b1;
          end else begin
            cur_addr_next  = base_addr;
            remaining_next = word_count;
            pending_next   = 1'b0;
            state_next     = space ? REQ : WAIT;
          end
        end
      end
      REQ: begin
        pending_next = 1'b1;
        state_next   = WAIT;
      end
      WAIT: begin
        if (pending) begin
          if (bus_ack) begin
            cur_addr_next  = cur_addr + 15'd1;
            remaining_next = remaining - 9'd1;
            pending_next   = 1'b0;
            if (remaining == 9'd1) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else if (space) begin
              state_next = REQ;
            end
          end else begin
            state_next = REQ;
          end
        end else if (space) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next     = IDLE;
      remaining_next = '0;
      pending_next   = 1'b0;
      done_next      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      pending   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      cur_addr  <= cur_addr_next;
      remaining <= remaining_next;
      pending   <= pending_next;
      done_q    <= done_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_after;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus_rddata;
  end

  // Head word is gated so stale storage never shows after reset or abort
  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign bus_strobe = (state == REQ);
  assign bus_addr   = bus_strobe ? cur_addr : '0;
  assign busy       = (state != IDLE);
  assign done       = done_q;

endmodule
